vend_ctrl: RTL and testbench

Parametrised successor to the single-price cola saler.
- Accepts jiao (0.5-yuan) and yuan coins and accumulates credit in half-yuan units against a configurable PRICE.
- Dispenses one item when credit reaches PRICE.
- Returns change or a cancel refund as a paced stream of coin pulses, gated by a coin-dispenser ready signal.
- Sits between the coin acceptor front end and the item/coin dispenser actuators.

---
 rtl/vend_ctrl.sv | 115 +++++++++++
 tb/tb_vend_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/vend_ctrl.sv
// Vending controller: accumulates jiao/yuan credit against PRICE, dispenses one
// item, then pays change or a cancel refund as paced coin pulses.
module vend_ctrl #(
  parameter int unsigned PRICE    = 5,
  parameter int unsigned CREDIT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_jiao,
  input  logic                in_yuan,
  input  logic                cancel,
  input  logic                coin_rdy,
  output logic [2:0]          state,
  output logic [CREDIT_W-1:0] credit,
  output logic                out_cola,
  output logic                out_yuan,
  output logic                out_jiao,
  output logic                coin_rej,
  output logic                busy
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] TWO_C   = CREDIT_W'(2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_VEND    = 3'd2,
    S_CHANGE  = 3'd3,
    S_REFUND  = 3'd4
  } state_t;

  state_t              state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] sum;
  logic [CREDIT_W-1:0] rem;
  logic                coin_in;

  // Value of the coin(s) presented this cycle and the arithmetic derived from it
  assign coin_val = CREDIT_W'({in_yuan, in_jiao});
  assign coin_in  = in_yuan | in_jiao;
  assign sum      = credit_q + coin_val;
  assign rem      = credit_q - PRICE_C;

  assign state  = state_q;
  assign credit = credit_q;
  assign busy   = (state_q == S_VEND) || (state_q == S_CHANGE) || (state_q == S_REFUND);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      out_cola <= 1'b0;
      out_yuan <= 1'b0;
      out_jiao <= 1'b0;
      coin_rej <= 1'b0;
    end else begin
      out_cola <= 1'b0;
      out_yuan <= 1'b0;
      out_jiao <= 1'b0;
      coin_rej <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (coin_in) begin
            credit_q <= coin_val;
            if (coin_val >= PRICE_C) begin
              state_q  <= S_VEND;
              out_cola <= 1'b1;
            end else begin
              state_q <= S_COLLECT;
            end
          end
        end
        // Reaching the price beats a same-cycle cancel; coins with cancel are refunded
        S_COLLECT: begin
          credit_q <= sum;
          if (sum >= PRICE_C) begin
            state_q  <= S_VEND;
            out_cola <= 1'b1;
          end else if (cancel) begin
            state_q <= S_REFUND;
          end
        end
        S_VEND: begin
          coin_rej <= coin_in;
          credit_q <= rem;
          state_q  <= (rem != '0) ? S_CHANGE : S_IDLE;
        end
        // One coin per ready cycle, largest denomination first
        S_CHANGE, S_REFUND: begin
          coin_rej <= coin_in;
          if (credit_q == '0) begin
            state_q <= S_IDLE;
          end else if (coin_rdy) begin
            if (credit_q >= TWO_C) begin
              out_yuan <= 1'b1;
              credit_q <= credit_q - TWO_C;
              if (credit_q == TWO_C) state_q <= S_IDLE;
            end else begin
              out_jiao <= 1'b1;
              credit_q <= '0;
              state_q  <= S_IDLE;
            end
          end
        end
        default: begin
          state_q  <= S_IDLE;
          credit_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl: default PRICE=5 instance plus a PRICE=1,
// CREDIT_W=2 instance sharing clock and reset.
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_jiao = 1'b0, in_yuan = 1'b0, cancel = 1'b0, coin_rdy = 1'b1;
  logic [2:0] state;
  logic [3:0] credit;
  logic       out_cola, out_yuan, out_jiao, coin_rej, busy;

  logic       jiao2 = 1'b0, yuan2 = 1'b0;
  logic [2:0] state2;
  logic [1:0] credit2;
  logic       cola2, oyuan2, ojiao2, rej2, busy2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vend_ctrl #(.PRICE(5), .CREDIT_W(4)) dut (
    .clk(clk), .rst(rst), .in_jiao(in_jiao), .in_yuan(in_yuan), .cancel(cancel),
    .coin_rdy(coin_rdy), .state(state), .credit(credit), .out_cola(out_cola),
    .out_yuan(out_yuan), .out_jiao(out_jiao), .coin_rej(coin_rej), .busy(busy)
  );

  vend_ctrl #(.PRICE(1), .CREDIT_W(2)) dut_p1 (
    .clk(clk), .rst(rst), .in_jiao(jiao2), .in_yuan(yuan2), .cancel(1'b0),
    .coin_rdy(1'b1), .state(state2), .credit(credit2), .out_cola(cola2),
    .out_yuan(oyuan2), .out_jiao(ojiao2), .coin_rej(rej2), .busy(busy2)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge
  task automatic step(input logic j, input logic y, input logic c, input logic r);
    in_jiao  = j;
    in_yuan  = y;
    cancel   = c;
    coin_rdy = r;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int st, input int cr,
                            input int cola, input int oy, input int oj, input int rej);
    check({tag, ".state"},    32'(state),    st);
    check({tag, ".credit"},   32'(credit),   cr);
    check({tag, ".out_cola"}, 32'(out_cola), cola);
    check({tag, ".out_yuan"}, 32'(out_yuan), oy);
    check({tag, ".out_jiao"}, 32'(out_jiao), oj);
    check({tag, ".coin_rej"}, 32'(coin_rej), rej);
  endtask

  initial begin
    #2;
    expect_out("reset", 0, 0, 0, 0, 0, 0);
    check("reset.busy", 32'(busy), 0);
    #10 rst = 1'b1;

    // 1: yuan x3 -> credit 2, 4, vend at 6, change one jiao
    step(0, 1, 0, 1); expect_out("t1.c1", 1, 2, 0, 0, 0, 0);
    step(0, 1, 0, 1); expect_out("t1.c2", 1, 4, 0, 0, 0, 0);
    step(0, 1, 0, 1); expect_out("t1.vend", 2, 6, 1, 0, 0, 0);
    check("t1.busy", 32'(busy), 1);
    step(0, 0, 0, 1); expect_out("t1.chg", 3, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1); expect_out("t1.pay", 0, 0, 0, 0, 1, 0);
    check("t1.idle_busy", 32'(busy), 0);
    step(0, 0, 0, 1); expect_out("t1.idle", 0, 0, 0, 0, 0, 0);

    // 2: jiao x5 -> exact price, no change
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 0, 1); expect_out($sformatf("t2.c%0d", i), 1, i, 0, 0, 0, 0);
    end
    step(1, 0, 0, 1); expect_out("t2.vend", 2, 5, 1, 0, 0, 0);
    step(0, 0, 0, 1); expect_out("t2.idle", 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1); expect_out("t2.quiet", 0, 0, 0, 0, 0, 0);

    // 3: yuan then jiao+yuan, once plain and once with cancel
    step(0, 1, 0, 1); expect_out("t3a.c1", 1, 2, 0, 0, 0, 0);
    step(1, 1, 0, 1); expect_out("t3a.vend", 2, 5, 1, 0, 0, 0);
    step(0, 0, 0, 1); expect_out("t3a.idle", 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1); expect_out("t3b.c1", 1, 2, 0, 0, 0, 0);
    step(1, 1, 1, 1); expect_out("t3b.vend", 2, 5, 1, 0, 0, 0);
    step(0, 0, 0, 1); expect_out("t3b.idle", 0, 0, 0, 0, 0, 0);

    // 4: credit 3 refunded as yuan then jiao, with a 4-cycle stall between
    step(0, 1, 0, 1); expect_out("t4.c1", 1, 2, 0, 0, 0, 0);
    step(1, 0, 0, 1); expect_out("t4.c2", 1, 3, 0, 0, 0, 0);
    step(0, 0, 1, 1); expect_out("t4.refund", 4, 3, 0, 0, 0, 0);
    step(0, 0, 0, 1); expect_out("t4.yuan", 4, 1, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0); expect_out($sformatf("t4.stall%0d", i), 4, 1, 0, 0, 0, 0);
    end
    step(0, 0, 0, 1); expect_out("t4.jiao", 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1); expect_out("t4.idle", 0, 0, 0, 0, 0, 0);

    // 5: yuan arriving during CHANGE is rejected and not credited
    step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
    expect_out("t5.vend", 2, 6, 1, 0, 0, 0);
    step(0, 0, 0, 0); expect_out("t5.chg", 3, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0); expect_out("t5.rej", 3, 1, 0, 0, 0, 1);
    step(0, 0, 0, 1); expect_out("t5.pay", 0, 0, 0, 0, 1, 0);

    // 6: reset asserted mid-refund clears everything at once
    step(0, 1, 0, 0); step(1, 0, 0, 0); step(0, 0, 1, 0);
    expect_out("t6.refund", 4, 3, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1 expect_out("t6.rst", 0, 0, 0, 0, 0, 0);
    check("t6.p1_state", 32'(state2), 0);
    #3 rst = 1'b1;
    step(1, 0, 0, 1); expect_out("t6.after", 1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1); expect_out("t6.refund2", 4, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1); expect_out("t6.pay", 0, 0, 0, 0, 1, 0);

    // PRICE=1, CREDIT_W=2: a yuan vends and returns one jiao
    yuan2 = 1'b1;
    step(0, 0, 0, 1);
    yuan2 = 1'b0;
    check("p1.vend_state", 32'(state2), 2);
    check("p1.vend_credit", 32'(credit2), 2);
    check("p1.cola", 32'(cola2), 1);
    step(0, 0, 0, 1);
    check("p1.chg_state", 32'(state2), 3);
    check("p1.chg_credit", 32'(credit2), 1);
    step(0, 0, 0, 1);
    check("p1.jiao", 32'(ojiao2), 1);
    check("p1.yuan", 32'(oyuan2), 0);
    check("p1.idle_state", 32'(state2), 0);
    check("p1.idle_credit", 32'(credit2), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
